ahb_timer_mc: RTL and testbench
===============================

# ahb_timer_mc

Multi-channel AHB-Lite timer: NUM_CH independent down-counters of CNT_W bits, each with free-running, periodic and one-shot modes, a per-channel power-of-two prescaler, and a sticky, maskable interrupt. It is the next-generation timer slave on the Cortex-M0 AHB-Lite bus. It provides one IRQ line per channel plus a combined line for the NVIC.

## Interface
- NUM_CH, 4: number of channels, 1..8.
- CNT_W, 32: counter/load width, 8..32; register reads are zero-extended to 32.
- HCLK  in  1  bus and timer clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL, HREADY, HWRITE  in  1 each  AHB-Lite address-phase controls.
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) qualifies a transfer.
- HADDR  in  32  byte address; bits [11:0] decoded.
- HWDATA  in  32  data-phase write data.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  constant 1.
- timer_irq  out  NUM_CH  per-channel raw sticky IRQ.
- irq  out  1  OR of (timer_irq & IRQ_MASK).

## Operation
- Address phase is registered when HREADY=1 (HSEL, HWRITE, HTRANS, HADDR). The write is applied in the data phase using HWDATA.
- Channel c registers sit at base 0x10*c:
  - LOAD +0x0: RW.
  - VALUE +0x4: RO; writes are ignored.
  - CTRL +0x8: RW. [0] EN; [2:1] MODE (00 free-running, 01 periodic, 10 one-shot, 11 acts as periodic); [7:4] PS, tick every 2^PS HCLK.
  - CLEAR +0xC: WO; writing bit0=1 clears the IRQ.
- Global registers:
  - IRQ_STATUS at 0x100: RO, timer_irq zero-extended.
  - IRQ_MASK at 0x104: RW, NUM_CH bits.
- Unmapped addresses and channels ≥ NUM_CH read 0; writes to them are ignored.
- Shared 15-bit prescaler counter is free-running from reset. Channel tick = (PS==0) or (pre_cnt[PS-1:0] all ones).
- Per-channel FSM:
  - IDLE: on EN & tick, VALUE←LOAD and go to COUNT.
  - COUNT, EN=0: VALUE frozen, state held; resumes when EN returns.
  - COUNT, EN & tick & VALUE≠0: VALUE−1.
  - COUNT, EN & tick & VALUE==0: set IRQ, then by mode:
    - free-running: wrap to all-ones (CNT_W).
    - periodic: VALUE←LOAD.
    - one-shot: VALUE stays 0, hardware clears CTRL.EN, go to IDLE.
- A LOAD write during COUNT takes effect only at the next reload or IDLE→COUNT.
- If a CLEAR write and an IRQ set occur in the same cycle, the set wins.

## Timing
- Reset values: all registers 0, FSMs in IDLE, prescaler 0; timer_irq=0, irq=0, HRDATA=0 (decode of reset address), HREADYOUT=1.
- A write whose data phase is in cycle N is visible in the register from cycle N+1. A counter effect occurs no earlier than N+1.
- Reads are zero-wait: HRDATA is combinational from the registered address and current register contents.
- timer_irq is registered: it asserts the cycle after the tick in which VALUE==0. irq follows in the same cycle combinationally.
- With PS=0 and LOAD=L in periodic mode, IRQ events occur every L+1 cycles. With LOAD=0, an event occurs on every tick.
- HRESET mid-count: all state returns to reset values immediately; any pending IRQ is lost.

## Configuration
- TIMER_PRESCALER_EN defined: prescaler counter and the CTRL[7:4] field exist.
- TIMER_PRESCALER_EN undefined: prescaler counter is removed. Tick=1 every cycle. CTRL[7:4] reads 0 and writes to it are ignored.

## Structure
- Package ahb_timer_pkg holds:
  - Offset constants: LOAD, VALUE, CTRL, CLEAR, IRQ_STATUS, IRQ_MASK.
  - Mode encodings.
  - Channel-state typedef (IDLE, COUNT).
  - CTRL bit-position constants.
- Sub-module timer_channel (parameter CNT_W) holds one FSM, its LOAD/VALUE/CTRL registers and the IRQ flop. The top level holds the AHB decode, prescaler, read mux and mask, and instantiates NUM_CH copies of timer_channel.

## Test plan
- Reset: assert HRESET mid-count → VALUE, CTRL, timer_irq and irq all read 0 next cycle; HREADYOUT=1 throughout.
- Channel 0 periodic: LOAD=4, CTRL=0x03, PS=0 → timer_irq[0] rises 6 cycles after the CTRL data phase; VALUE sequence is 4,3,2,1,0,4.
- Channel 1 one-shot: LOAD=2, CTRL=0x05 → a single IRQ; CTRL reads 0x04 afterwards and VALUE stays 0.
- Channel 2 free-running, CNT_W=8: LOAD=0, EN → after 0, VALUE reads 0xFF, then 0xFE.
- Prescaler (macro defined): PS=2, LOAD=1, periodic → VALUE decrements only every 4th cycle. With the macro undefined, the same write decrements every cycle and CTRL reads 0x03.
- IRQ handling:
  - Mask=0 → timer_irq set while irq stays 0.
  - Then mask=1 → irq=1.
  - A CLEAR write in the same cycle as a new set event → timer_irq remains 1.
  - An unmapped read at 0x1F0 → 0.

Source files
------------

// File: rtl/ahb_timer_pkg.sv
// ahb_timer_pkg: register map, mode encodings and channel state
// shared by the ahb_timer_mc top and its timer_channel instances.
package ahb_timer_pkg;

  localparam logic [3:0]  OFF_LOAD   = 4'h0;
  localparam logic [3:0]  OFF_VALUE  = 4'h4;
  localparam logic [3:0]  OFF_CTRL   = 4'h8;
  localparam logic [3:0]  OFF_CLEAR  = 4'hC;
  localparam logic [11:0] IRQ_STATUS = 12'h100;
  localparam logic [11:0] IRQ_MASK   = 12'h104;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_PS_LSB   = 4;

  localparam int PRE_W = 15;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PERIOD2  = 2'b11
  } mode_e;

  typedef enum logic {
    CH_IDLE,
    CH_COUNT
  } ch_state_e;

  // tick when the low PS prescaler bits are all ones
  function automatic logic ps_tick(
    input logic [PRE_W-1:0] pre,
    input logic [3:0]       ps
  );
    logic [PRE_W:0] m;
    m = (16'd1 << ps) - 16'd1;
    return ({1'b0, pre} & m) == m;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counter with LOAD/VALUE/CTRL registers,
// its IDLE/COUNT FSM and a sticky IRQ flop.
module timer_channel
  import ahb_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             load_we_i,
  input  logic             ctrl_we_i,
  input  logic             clr_we_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] load_o,
  output logic [CNT_W-1:0] value_o,
  output logic [7:0]       ctrl_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic             en_q, en_d;
  logic             irq_q, irq_d;
  mode_e            mode_q, mode_d;
`ifdef TIMER_PRESCALER_EN
  logic [3:0]       ps_q, ps_d;
`else
  logic             unused;
  assign unused = ^wdata_i[7:4];
`endif

  // bus writes first, then counter events so hardware wins ties
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    value_d = value_q;
    en_d    = en_q;
    irq_d   = irq_q;
    mode_d  = mode_q;
`ifdef TIMER_PRESCALER_EN
    ps_d    = ps_q;
`endif
    if (load_we_i) load_d = wdata_i;
    if (ctrl_we_i) begin
      en_d   = wdata_i[CTRL_EN];
      mode_d = mode_e'(wdata_i[CTRL_MODE_LSB +: 2]);
`ifdef TIMER_PRESCALER_EN
      ps_d   = wdata_i[CTRL_PS_LSB +: 4];
`endif
    end
    if (clr_we_i && wdata_i[0]) irq_d = 1'b0;
    if (en_q && tick_i) begin
      case (state_q)
        CH_IDLE: begin
          value_d = load_q;
          state_d = CH_COUNT;
        end
        default: begin
          if (value_q != '0) begin
            value_d = value_q - ONE;
          end else begin
            irq_d = 1'b1;
            case (mode_q)
              MODE_FREE: value_d = '1;
              MODE_ONESHOT: begin
                value_d = '0;
                en_d    = 1'b0;
                state_d = CH_IDLE;
              end
              default: value_d = load_q;
            endcase
          end
        end
      endcase
    end
  end

  // channel state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CH_IDLE;
      load_q  <= '0;
      value_q <= '0;
      en_q    <= 1'b0;
      irq_q   <= 1'b0;
      mode_q  <= MODE_FREE;
`ifdef TIMER_PRESCALER_EN
      ps_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      value_q <= value_d;
      en_q    <= en_d;
      irq_q   <= irq_d;
      mode_q  <= mode_d;
`ifdef TIMER_PRESCALER_EN
      ps_q    <= ps_d;
`endif
    end
  end

  assign load_o  = load_q;
  assign value_o = value_q;
  assign irq_o   = irq_q;
`ifdef TIMER_PRESCALER_EN
  assign ctrl_o  = {ps_q, 1'b0, mode_q, en_q};
`else
  assign ctrl_o  = {4'b0, 1'b0, mode_q, en_q};
`endif

endmodule

// File: rtl/ahb_timer_mc.sv
// ahb_timer_mc: NUM_CH-channel AHB-Lite timer slave.
// Define TIMER_PRESCALER_EN for the shared prescaler and CTRL.PS.
module ahb_timer_mc
  import ahb_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic [NUM_CH-1:0] timer_irq,
  output logic              irq
);

  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic        we;
  logic        ch_rgn;
  logic [3:0]  ch_idx;
  logic [3:0]  off;
  logic        unused;

  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  load_a  [NUM_CH];
  logic [CNT_W-1:0]  value_a [NUM_CH];
  logic [7:0]        ctrl_a  [NUM_CH];
  logic [NUM_CH-1:0] irq_a;

  assign unused = ^{HADDR[31:12], HTRANS[0], HWDATA};

  // capture the address phase only when the bus is ready
  always_comb begin
    sel_d  = sel_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    if (HREADY) begin
      sel_d  = HSEL & HTRANS[1];
      wr_d   = HWRITE;
      addr_d = HADDR[11:0];
    end
  end

  // address phase registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      sel_q  <= sel_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
    end
  end

  assign we     = sel_q & wr_q;
  assign ch_rgn = (addr_q[11:8] == 4'h0);
  assign ch_idx = addr_q[7:4];
  assign off    = addr_q[3:0];

  // interrupt mask write
  always_comb begin
    mask_d = mask_q;
    if (we && addr_q == IRQ_MASK) mask_d = HWDATA[NUM_CH-1:0];
  end

  // interrupt mask register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) mask_q <= '0;
    else        mask_q <= mask_d;
  end

`ifdef TIMER_PRESCALER_EN
  logic [PRE_W-1:0] pre_q;

  // shared free-running prescaler
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) pre_q <= '0;
    else        pre_q <= pre_q + PRE_W'(1);
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    logic tick;
    assign hit = we & ch_rgn & (ch_idx == 4'(c));
`ifdef TIMER_PRESCALER_EN
    assign tick = ps_tick(pre_q, ctrl_a[c][CTRL_PS_LSB +: 4]);
`else
    assign tick = 1'b1;
`endif
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i    (HCLK),
      .rst_i    (HRESET),
      .tick_i   (tick),
      .load_we_i(hit & (off == OFF_LOAD)),
      .ctrl_we_i(hit & (off == OFF_CTRL)),
      .clr_we_i (hit & (off == OFF_CLEAR)),
      .wdata_i  (HWDATA[CNT_W-1:0]),
      .load_o   (load_a[c]),
      .value_o  (value_a[c]),
      .ctrl_o   (ctrl_a[c]),
      .irq_o    (irq_a[c])
    );
  end

  // read mux from the registered address
  always_comb begin
    HRDATA = '0;
    if (ch_rgn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (off)
            OFF_LOAD:  HRDATA = 32'(load_a[c]);
            OFF_VALUE: HRDATA = 32'(value_a[c]);
            OFF_CTRL:  HRDATA = 32'(ctrl_a[c]);
            default:   HRDATA = '0;
          endcase
        end
      end
    end else if (addr_q == IRQ_STATUS) begin
      HRDATA = 32'(irq_a);
    end else if (addr_q == IRQ_MASK) begin
      HRDATA = 32'(mask_q);
    end
  end

  assign HREADYOUT = 1'b1;
  assign timer_irq = irq_a;
  assign irq       = |(irq_a & mask_q);

endmodule

// File: tb/tb_ahb_timer_mc.sv
// tb_ahb_timer_mc: directed AHB reads with hand-computed values,
// queued by the stimulus and checked by a data-phase monitor.
module tb_ahb_timer_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              HSEL = 1'b0;
  logic              HREADY = 1'b1;
  logic              HWRITE = 1'b0;
  logic [1:0]        HTRANS = 2'b00;
  logic [31:0]       HADDR = '0;
  logic [31:0]       HWDATA = '0;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic [NUM_CH-1:0] timer_irq;
  logic              irq;

  ahb_timer_mc #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HREADY   (HREADY),
    .HWRITE   (HWRITE),
    .HTRANS   (HTRANS),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .timer_irq(timer_irq),
    .irq      (irq)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0]       data;
    logic              chk;
    logic [NUM_CH-1:0] tirq;
    logic              irq;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  rd_dp;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
    end
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) rd_dp <= 1'b0;
    else        rd_dp <= HSEL && HTRANS[1] && !HWRITE && HREADY;
  end

  always @(negedge HCLK) begin
    exp_t  e;
    string nm;
    if (rd_dp) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%0h expected none", HRDATA);
      end else begin
        e  = q.pop_front();
        nm = qn.pop_front();
        cmp(nm, HRDATA, e.data);
        cmp({nm, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        if (e.chk) begin
          cmp({nm, "_timer_irq"}, 32'(timer_irq), 32'(e.tirq));
          cmp({nm, "_irq"}, 32'(irq), 32'(e.irq));
        end
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = a;
    step();
    HWDATA = d;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a,
                    input logic [31:0] ex, input bit ck = 1'b0,
                    input logic [NUM_CH-1:0] ti = '0,
                    input logic ir = 1'b0);
    exp_t e;
    e.data = ex;
    e.chk  = ck;
    e.tirq = ti;
    e.irq  = ir;
    q.push_back(e);
    qn.push_back(nm);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = a;
    step();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  int pv[10];
  int pt[10];
  int ctrl3;

  initial begin
`ifdef TIMER_PRESCALER_EN
    pv    = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    pt    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    ctrl3 = 32'h23;
`else
    pv    = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    pt    = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    ctrl3 = 32'h03;
`endif
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    rd("rst_status", 32'h100, 0, 1, 4'h0, 0);
    rd("rst_ctrl0", 32'h008, 0, 1, 4'h0, 0);
    rd("rst_value0", 32'h004, 0);
    rd("rst_mask", 32'h104, 0);

    wr(32'h000, 4);
    wr(32'h008, 32'h03);
    idle(1);
    rd("per_v4", 32'h004, 4, 1, 4'h0, 0);
    rd("per_v3", 32'h004, 3, 1, 4'h0, 0);
    rd("per_v2", 32'h004, 2, 1, 4'h0, 0);
    rd("per_v1", 32'h004, 1, 1, 4'h0, 0);
    rd("per_v0", 32'h004, 0, 1, 4'h0, 0);
    rd("per_reload", 32'h004, 4, 1, 4'h1, 0);
    wr(32'h008, 0);
    wr(32'h00C, 1);
    wr(32'h004, 32'h55);
    rd("value_ro", 32'h004, 2, 1, 4'h0, 0);

    wr(32'h010, 2);
    wr(32'h018, 32'h05);
    idle(6);
    rd("os_ctrl", 32'h018, 32'h04);
    rd("os_value", 32'h014, 0);
    rd("os_status", 32'h100, 2, 1, 4'h2, 0);
    wr(32'h01C, 1);
    idle(5);
    rd("os_single", 32'h100, 0, 1, 4'h0, 0);
    rd("os_value2", 32'h014, 0);

    wr(32'h020, 0);
    wr(32'h028, 32'h01);
    rd("fr_idle", 32'h024, 0, 1, 4'h0, 0);
    rd("fr_load", 32'h024, 0, 1, 4'h0, 0);
    rd("fr_wrap", 32'h024, 32'hFF, 1, 4'h4, 0);
    rd("fr_dec", 32'h024, 32'hFE, 1, 4'h4, 0);
    wr(32'h028, 0);
    wr(32'h02C, 1);
    idle(2);

    wr(32'h008, 32'h03);
    rd("irq_v2", 32'h004, 2);
    rd("irq_v1", 32'h004, 1);
    rd("irq_v0", 32'h004, 0);
    rd("irq_masked", 32'h100, 1, 1, 4'h1, 0);
    wr(32'h104, 1);
    rd("irq_mask_rd", 32'h104, 1, 1, 4'h1, 1);
    rd("irq_v1b", 32'h004, 1);
    wr(32'h00C, 1);
    rd("irq_set_wins", 32'h100, 1, 1, 4'h1, 1);
    wr(32'h00C, 1);
    rd("irq_cleared", 32'h100, 0, 1, 4'h0, 0);
    rd("unmapped", 32'h1F0, 0);
    rd("no_channel", 32'h040, 0);
    idle(3);

    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;

    wr(32'h030, 1);
    wr(32'h038, 32'h23);
    for (int j = 0; j < 10; j++) begin
      rd($sformatf("ps_v%0d", j), 32'h034, 32'(pv[j]), 1,
         pt[j] != 0 ? 4'h8 : 4'h0, 0);
    end
    rd("ps_ctrl", 32'h038, 32'(ctrl3));
    rd("rst_ch0_value", 32'h004, 0);
    rd("rst_ch0_ctrl", 32'h008, 0);
    rd("rst_ch0_load", 32'h000, 0);
    rd("rst_mask2", 32'h104, 0, 1, 4'h8, 0);
    idle(2);

    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
